uart_tx_axis: RTL
=================

Name: uart_tx_axis

Overview:
AXI4-Stream slave that consumes bytes from the UART transmit-path FIFO master port (tdata/tvalid/tready/tlast) and serialises each byte onto the UART tx line. Frame: start bit, DATA_WIDTH data bits LSB first, optional parity, STOP_BITS stop bits. Sits between the transmit FIFO and the pad, in the same clock domain. One byte is accepted per frame.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..9.
CLKS_PER_BIT, 868, s_aclk cycles per bit; minimum 2. Default gives 115200 baud at 100 MHz.
STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
s_aclk  in  1  clock
s_aresetn  in  1  asynchronous active-low reset
s_axis_tdata  in  DATA_WIDTH  byte to transmit
s_axis_tvalid  in  1  upstream data valid
s_axis_tready  out  1  block ready to accept one byte
s_axis_tlast  in  1  packet-end marker, captured with the byte
tx  out  1  serial line, idle high
tx_busy  out  1  high while a frame is on the line
tx_done  out  1  1-cycle pulse at frame completion
tx_done_last  out  1  1-cycle pulse coincident with tx_done when the captured tlast was 1

Behaviour:
- Clock and reset: single clock s_aclk; reset s_aresetn is asynchronous and active-low.
- All outputs are registered.
- Reset values: tx=1, s_axis_tready=0, tx_busy=0, tx_done=0, tx_done_last=0, state=IDLE, baud counter=0, bit index=0.
- s_axis_tready rises on the first s_aclk edge after reset release.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE: tready=1, tx=1, busy=0.
  - On handshake (tvalid && tready) at edge T: capture tdata into a shift register and capture tlast.
  - At T+1: tready=0, busy=1, tx=0, state=START.
- Baud counter runs 0..CLKS_PER_BIT-1. Each bit is held for exactly CLKS_PER_BIT cycles.
- Bit timing:
  - START: tx=0 for cycles T+1..T+CPB.
  - DATA: bit i is driven from T+1+(1+i)*CPB, LSB first.
  - STOP: tx=1 for STOP_BITS*CPB cycles.
- Let N = 1 + DATA_WIDTH + P + STOP_BITS, where P=1 when parity is compiled in, else 0.
- At T+1+N*CPB: state=IDLE, tready=1, busy=0, tx=1, tx_done=1 for one cycle, tx_done_last=captured tlast.
- A new handshake is allowed in that same cycle. Back-to-back frames with tvalid held high are therefore spaced N*CPB+1 cycles apart, with no start-bit glitch between them.
- While busy, tdata/tvalid/tlast are ignored; changing them has no effect on the line.
- tvalid may stay high indefinitely in IDLE only if tready is low (during reset). Otherwise the byte is taken on the first IDLE edge.
- Reset asserted mid-frame: tx goes to 1 and busy to 0 immediately (asynchronous). The partial frame is abandoned with no tx_done, and the byte is lost.
- Counter width is $clog2(CLKS_PER_BIT). The bit index saturates at DATA_WIDTH-1, then the FSM advances.

Optional Feature:
UART_TX_PARITY_EN:
- Defined: a PARITY state follows DATA and drives even parity (XOR of the captured data bits) for CLKS_PER_BIT cycles. P=1.
- Undefined: no PARITY state; DATA goes directly to STOP. P=0. No parity logic is synthesised.

Test Plan:
1. Reset asserted with tvalid=1 -> tx=1, tready=0, busy=0. After release, tready=1 on the first edge and the byte is taken on the next edge; tx low one cycle later.
2. CPB=4, no parity, STOP_BITS=1, send 0xA5 with tlast=0 -> tx: 0x4, then 1,0,1,0,0,1,0,1 each x4, then 1x4. tx_done at T+41, tx_done_last=0.
3. tvalid held, 0x00 then 0xFF with tlast=1 on the second -> handshakes 41 cycles apart. tx_done pulses twice; tx_done_last only on the second. No idle gap beyond one cycle.
4. Reset pulsed during data bit 3 of 0x5A -> tx=1 and busy=0 immediately, no tx_done. After release, 0x3C is transmitted correctly.
5. During a frame, toggle tvalid and change tdata every cycle -> tx waveform identical to case 2, and tready=0 for the whole frame.
6. With UART_TX_PARITY_EN and STOP_BITS=2, CPB=4 -> 0xA5 gives parity bit 0 and 0x07 gives parity bit 1. tx_done at T+49 (N=12).

Source files
------------

// File: rtl/uart_tx_axis.sv
// rtl/uart_tx_axis.sv - AXI-Stream byte to UART serial transmitter (optional even parity via UART_TX_PARITY_EN)
module uart_tx_axis #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic                  s_aclk,
    input  logic                  s_aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done,
    output logic                  tx_done_last
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      baud_cnt;
    logic [BIT_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  last_q;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q;
`endif

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            state         <= IDLE;
            baud_cnt      <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            last_q        <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q      <= 1'b0;
`endif
            tx            <= 1'b1;
            s_axis_tready <= 1'b0;
            tx_busy       <= 1'b0;
            tx_done       <= 1'b0;
            tx_done_last  <= 1'b0;
        end else begin
            tx_done      <= 1'b0;
            tx_done_last <= 1'b0;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (s_axis_tvalid && s_axis_tready) begin
                        shreg         <= s_axis_tdata;
                        last_q        <= s_axis_tlast;
`ifdef UART_TX_PARITY_EN
                        parity_q      <= ^s_axis_tdata;
`endif
                        state         <= START;
                        s_axis_tready <= 1'b0;
                        tx_busy       <= 1'b1;
                        tx            <= 1'b0;
                    end else begin
                        s_axis_tready <= 1'b1;
                        tx_busy       <= 1'b0;
                        tx            <= 1'b1;
                    end
                end
                START: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= shreg[0];
                        shreg    <= {1'b0, shreg[DATA_WIDTH-1:1]};
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= parity_q;
                            state <= PARITY;
`else
                            tx      <= 1'b1;
                            bit_idx <= '0;
                            state   <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shreg[0];
                            shreg   <= {1'b0, shreg[DATA_WIDTH-1:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    // bit_idx is reused here to count stop bits
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == STOP_LAST) begin
                            bit_idx       <= '0;
                            state         <= IDLE;
                            s_axis_tready <= 1'b1;
                            tx_busy       <= 1'b0;
                            tx            <= 1'b1;
                            tx_done       <= 1'b1;
                            tx_done_last  <= last_q;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    baud_cnt      <= '0;
                    bit_idx       <= '0;
                    tx            <= 1'b1;
                    s_axis_tready <= 1'b0;
                    tx_busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
